// File: rtl/grf_wdata_pipe_pkg.sv
// Shared encodings for the GRF write-data pipeline: write-source select codes
// and the hard-wired zero register.
package grf_wdata_pipe_pkg;

    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_ANS    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_MEM    = 2'b01;
    localparam logic [SEL_W-1:0] SEL_PCLINK = 2'b10;
    localparam logic [SEL_W-1:0] SEL_RSVD   = 2'b11;

    // Register $0 is never written, so writes to it are never valid in the pipe.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/grf_wdata_pipe_stage_reg.sv
// Generic write-back pipeline register: valid/addr/data/sel/tnew fields with a
// bubble (clear) control that outranks hold.
module wdata_stage_reg
    import grf_wdata_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              bubble,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic              q_valid,
    output logic [ADDR_W-1:0] q_addr,
    output logic [DATA_W-1:0] q_data,
    output logic [SEL_W-1:0]  q_sel,
    output logic [TNEW_W-1:0] q_tnew
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_addr  <= '0;
            q_data  <= '0;
            q_sel   <= '0;
            q_tnew  <= '0;
        end else if (bubble) begin
            q_valid <= 1'b0;
            q_addr  <= '0;
            q_data  <= '0;
            q_sel   <= '0;
            q_tnew  <= '0;
        end else if (!hold) begin
            q_valid <= d_valid;
            q_addr  <= d_addr;
            q_data  <= d_data;
            q_sel   <= d_sel;
            q_tnew  <= d_tnew;
        end
    end

endmodule

// File: rtl/grf_wdata_pipe.sv
// GRF write-data pipeline: resolves the write source in E, carries the write
// through E/M and M/W registers, and exposes Tnew-qualified forwarding per stage.
module grf_wdata_pipe
    import grf_wdata_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int TNEW_W    = 2,
    parameter int PC_OFFSET = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_valid,
    input  logic [1:0]        e_sel,
    input  logic [DATA_W-1:0] e_ans,
    input  logic [DATA_W-1:0] e_pc,
    input  logic [ADDR_W-1:0] e_waddr,
    input  logic [TNEW_W-1:0] e_tnew,
    input  logic              stall_m,
    input  logic              flush_m,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] fwd_m_addr,
    output logic [DATA_W-1:0] fwd_m_data,
    output logic              fwd_m_ready,
    output logic [ADDR_W-1:0] fwd_w_addr,
    output logic [DATA_W-1:0] fwd_w_data,
    output logic              grf_we,
    output logic [ADDR_W-1:0] grf_waddr,
    output logic [DATA_W-1:0] grf_wdata
);

    logic              e_wr_valid;
    logic [DATA_W-1:0] e_data;
    logic [TNEW_W-1:0] e_tnew_next;

    logic              m_valid;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_data;
    logic [SEL_W-1:0]  m_sel;
    logic [TNEW_W-1:0] m_tnew;
    logic [DATA_W-1:0] m_wdata;

    logic              w_valid;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_data;
    logic [SEL_W-1:0]  w_sel;
    logic [TNEW_W-1:0] w_tnew;
    logic              unused_w_meta;

    assign e_wr_valid  = e_valid && (e_waddr != ADDR_W'(REG_ZERO));
    assign e_tnew_next = (e_tnew == '0) ? '0 : e_tnew - TNEW_W'(1);

    // Link address wraps modulo 2^DATA_W; the reserved code falls back to ANS.
    always_comb begin
        e_data = e_ans;
        case (e_sel)
            SEL_PCLINK:                  e_data = e_pc + DATA_W'(PC_OFFSET);
            SEL_ANS, SEL_MEM, SEL_RSVD:  e_data = e_ans;
            default:                     e_data = e_ans;
        endcase
    end

    wdata_stage_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TNEW_W (TNEW_W)
    ) u_m_stage (
        .clk     (clk),
        .reset   (reset),
        .hold    (stall_m),
        .bubble  (flush_m),
        .d_valid (e_wr_valid),
        .d_addr  (e_waddr),
        .d_data  (e_data),
        .d_sel   (e_sel),
        .d_tnew  (e_tnew_next),
        .q_valid (m_valid),
        .q_addr  (m_waddr),
        .q_data  (m_data),
        .q_sel   (m_sel),
        .q_tnew  (m_tnew)
    );

    assign fwd_m_addr  = m_valid ? m_waddr : '0;
    assign fwd_m_data  = m_data;
    assign fwd_m_ready = m_valid && (m_tnew == '0) && (m_sel != SEL_MEM);

    // Loads pick up the DM read data only as they leave M.
    assign m_wdata = (m_sel == SEL_MEM) ? m_rdata : m_data;

    // A stalled M must not also advance into W, so W takes a bubble instead.
    wdata_stage_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TNEW_W (TNEW_W)
    ) u_w_stage (
        .clk     (clk),
        .reset   (reset),
        .hold    (1'b0),
        .bubble  (stall_m | flush_m),
        .d_valid (m_valid),
        .d_addr  (m_waddr),
        .d_data  (m_wdata),
        .d_sel   (m_sel),
        .d_tnew  (TNEW_W'(0)),
        .q_valid (w_valid),
        .q_addr  (w_waddr),
        .q_data  (w_data),
        .q_sel   (w_sel),
        .q_tnew  (w_tnew)
    );

    assign unused_w_meta = ^{w_sel, w_tnew};

    assign grf_we     = w_valid;
    assign grf_waddr  = w_valid ? w_waddr : '0;
    assign grf_wdata  = w_data;
    assign fwd_w_addr = grf_waddr;
    assign fwd_w_data = w_data;

endmodule

// File: tb/tb_grf_wdata_pipe.sv
// Scoreboard bench for grf_wdata_pipe: directed cases plus random traffic checked
// against an instruction-level reference model of the write-back path.
module tb_grf_wdata_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        e_valid = 1'b0;
    logic [1:0]  e_sel = '0;
    logic [31:0] e_ans = '0;
    logic [31:0] e_pc = '0;
    logic [4:0]  e_waddr = '0;
    logic [1:0]  e_tnew = '0;
    logic        stall_m = 1'b0;
    logic        flush_m = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [4:0]  fwd_m_addr;
    logic [31:0] fwd_m_data;
    logic        fwd_m_ready;
    logic [4:0]  fwd_w_addr;
    logic [31:0] fwd_w_data;
    logic        grf_we;
    logic [4:0]  grf_waddr;
    logic [31:0] grf_wdata;

    grf_wdata_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .e_valid     (e_valid),
        .e_sel       (e_sel),
        .e_ans       (e_ans),
        .e_pc        (e_pc),
        .e_waddr     (e_waddr),
        .e_tnew      (e_tnew),
        .stall_m     (stall_m),
        .flush_m     (flush_m),
        .m_rdata     (m_rdata),
        .fwd_m_addr  (fwd_m_addr),
        .fwd_m_data  (fwd_m_data),
        .fwd_m_ready (fwd_m_ready),
        .fwd_w_addr  (fwd_w_addr),
        .fwd_w_data  (fwd_w_data),
        .grf_we      (grf_we),
        .grf_waddr   (grf_waddr),
        .grf_wdata   (grf_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: the instruction currently sitting in M, and expected GRF writes.
    typedef struct {
        bit          live;
        int unsigned rd;
        int unsigned value;
        bit          is_load;
        int unsigned cycles_to_ready;
    } instr_t;

    typedef struct {
        int unsigned rd;
        int unsigned value;
    } write_t;

    instr_t in_m;
    bit     write_due = 1'b0;
    write_t exp_wr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_clear();
        in_m      = '{live: 1'b0, rd: 0, value: 0, is_load: 1'b0, cycles_to_ready: 0};
        write_due = 1'b0;
        exp_wr_q.delete();
    endfunction

    // Apply one rising edge's worth of architectural effect using the inputs present at it.
    function automatic void model_edge();
        int unsigned src;
        if (reset) begin
            model_clear();
            return;
        end
        write_due = 1'b0;
        if (!stall_m && !flush_m && in_m.live) begin
            exp_wr_q.push_back('{rd: in_m.rd, value: in_m.is_load ? int'(m_rdata) : in_m.value});
            write_due = 1'b1;
        end
        if (flush_m) begin
            in_m = '{live: 1'b0, rd: 0, value: 0, is_load: 1'b0, cycles_to_ready: 0};
        end else if (!stall_m) begin
            src = (e_sel == 2'd2) ? (int'(e_pc) + 8) : int'(e_ans);
            in_m.live            = e_valid && (e_waddr != 0);
            in_m.rd              = e_waddr;
            in_m.value           = src;
            in_m.is_load         = (e_sel == 2'd1);
            in_m.cycles_to_ready = (e_tnew == 0) ? 0 : e_tnew - 1;
        end
    endfunction

    task automatic cyc(input bit v, input bit [1:0] sel, input bit [31:0] ans, input bit [31:0] pc,
                       input bit [4:0] wa, input bit [1:0] tn, input bit st, input bit fl,
                       input bit [31:0] rd);
        e_valid = v; e_sel = sel; e_ans = ans; e_pc = pc; e_waddr = wa; e_tnew = tn;
        stall_m = st; flush_m = fl; m_rdata = rd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input bit st, input bit fl, input bit [31:0] rd);
        cyc(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 2'd0, st, fl, rd);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " fwd_m_addr"}, 32'(fwd_m_addr), 32'h0);
        chk({tag, " fwd_m_data"}, fwd_m_data, 32'h0);
        chk({tag, " fwd_m_ready"}, 32'(fwd_m_ready), 32'h0);
        chk({tag, " fwd_w_addr"}, 32'(fwd_w_addr), 32'h0);
        chk({tag, " fwd_w_data"}, fwd_w_data, 32'h0);
        chk({tag, " grf_we"}, 32'(grf_we), 32'h0);
        chk({tag, " grf_waddr"}, 32'(grf_waddr), 32'h0);
        chk({tag, " grf_wdata"}, grf_wdata, 32'h0);
    endtask

    // Monitor: compares M forwarding every cycle and pops a write whenever W presents one.
    always @(negedge clk) begin
        write_t w;
        chk("fwd_m_addr", 32'(fwd_m_addr), in_m.live ? in_m.rd : 32'h0);
        if (in_m.live) chk("fwd_m_data", fwd_m_data, in_m.value);
        chk("fwd_m_ready", 32'(fwd_m_ready),
            32'(in_m.live && !in_m.is_load && in_m.cycles_to_ready == 0));
        chk("grf_we", 32'(grf_we), 32'(write_due));
        if (grf_we) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++;
                $display("FAIL grf_write: unexpected write addr %0d data 0x%08h at %0t",
                         grf_waddr, grf_wdata, $time);
            end else begin
                w = exp_wr_q.pop_front();
                $display("write r%0d <= 0x%08h (expected r%0d <= 0x%08h)",
                         grf_waddr, grf_wdata, w.rd, w.value);
                chk("grf_waddr", 32'(grf_waddr), w.rd);
                chk("grf_wdata", grf_wdata, w.value);
                chk("fwd_w_addr", 32'(fwd_w_addr), w.rd);
                chk("fwd_w_data", fwd_w_data, w.value);
            end
        end else begin
            chk("grf_waddr idle", 32'(grf_waddr), 32'h0);
            chk("fwd_w_addr idle", 32'(fwd_w_addr), 32'h0);
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // ALU result, link (incl. wrap), load, write to $0
        cyc(1'b1, 2'd0, 32'h1234, 32'h0, 5'd8, 2'd1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 2'd2, 32'h0, 32'h0000_3000, 5'd31, 2'd0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 5'd30, 2'd0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 2'd1, 32'h55, 32'h0, 5'd4, 2'd2, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 2'd0, 32'h5, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        cyc(1'b1, 2'd3, 32'hA5A5_0001, 32'h40, 5'd9, 2'd0, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);

        // Load held in M by a 2-cycle stall, then written
        cyc(1'b1, 2'd1, 32'h0, 32'h0, 5'd12, 2'd2, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'hCAFE_0000);
        idle(1'b1, 1'b0, 32'hCAFE_0001);
        idle(1'b0, 1'b0, 32'h1357_9BDF);
        idle(1'b0, 1'b0, 32'h0);

        // Flush together with stall drops the instruction in M
        cyc(1'b1, 2'd0, 32'h7777, 32'h0, 5'd13, 2'd0, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b1, 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);

        // Asynchronous reset between edges with M and W both valid
        cyc(1'b1, 2'd0, 32'h1111, 32'h0, 5'd1, 2'd0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 2'd0, 32'h2222, 32'h0, 5'd2, 2'd0, 1'b0, 1'b0, 32'h0);
        e_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        model_clear();
        @(posedge clk);
        model_edge();
        #1 reset = 1'b0;
        idle(1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                2'($urandom), 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 11) == 0),
                $urandom);
        end
        repeat (3) idle(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("writes drained", 32'(exp_wr_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/grf_wdata_pipe.md
Name: grf_wdata_pipe

Overview:
Parametrised successor to the single-stage E write-data select. It resolves the GRF write-data source (ALU result, PC link, memory read data) and carries write address/data/valid through the E/M and M/W pipeline registers. Each stage exposes Tnew-qualified forwarding outputs, and the W stage drives the GRF write port. It sits between the E-stage ALU, the M-stage DM, and the GRF/hazard unit.

Parameters:
DATA_W, 32, width of write data, ALU result and PC.
ADDR_W, 5, GRF register address width.
TNEW_W, 2, width of the Tnew field.
PC_OFFSET, 8, link offset added to e_pc for PCLINK (jal/jalr: PC+8).

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high; clears all stage registers.
e_valid  in  1  E-stage instruction writes the GRF.
e_sel  in  2  source: 00 ANS, 01 MEM, 10 PCLINK, 11 reserved (treated as ANS).
e_ans  in  DATA_W  ALU result.
e_pc  in  DATA_W  PC of the E-stage instruction.
e_waddr  in  ADDR_W  destination register.
e_tnew  in  TNEW_W  Tnew of the instruction while it is in E.
stall_m  in  1  hold M; bubble into W.
flush_m  in  1  load bubble into M.
m_rdata  in  DATA_W  DM read data for the M-stage instruction, already extended.
fwd_m_addr  out  ADDR_W  M-stage destination (0 if invalid).
fwd_m_data  out  DATA_W  M-stage resolved data.
fwd_m_ready  out  1  M data is forwardable.
fwd_w_addr  out  ADDR_W  W-stage destination (0 if invalid).
fwd_w_data  out  DATA_W  W-stage data.
grf_we  out  1  GRF write enable.
grf_waddr  out  ADDR_W  GRF write address.
grf_wdata  out  DATA_W  GRF write data.

Behaviour:
- Reset, asynchronous: all M/W valid, addr, data, sel and tnew registers go to 0. Every output is then 0.
- Effective valid at capture: v = e_valid & (e_waddr != 0). Writes to $0 are never valid anywhere in the pipe.
- E->M capture on each rising edge, with priority flush_m > stall_m > load:
  - flush_m=1: M loads a bubble (all zero).
  - stall_m=1 and flush_m=0: M holds all fields.
  - otherwise M loads v, e_waddr, e_sel, and m_tnew = (e_tnew==0) ? 0 : e_tnew-1.
  - m_data = e_pc + PC_OFFSET when sel=PCLINK (modulo 2^DATA_W, carry dropped); otherwise e_ans. Reserved 11 uses ANS.
- M outputs:
  - fwd_m_addr = m_valid ? m_waddr : 0.
  - fwd_m_data = m_data.
  - fwd_m_ready = m_valid & (m_tnew==0) & (m_sel != MEM).
- M->W capture on each rising edge:
  - stall_m=1 or flush_m=1: W loads a bubble.
  - otherwise W loads m_valid, m_waddr, and w_data = (m_sel==MEM) ? m_rdata : m_data.
  - m_rdata is sampled only on this edge.
- W outputs: grf_we = w_valid; grf_waddr = fwd_w_addr = w_valid ? w_waddr : 0; grf_wdata = fwd_w_data = w_data. W data is always ready (Tnew=0).
- Latency: E-captured data appears on fwd_m_* 1 cycle after capture and on grf_* 2 cycles after, plus 1 cycle per stall_m cycle.
- Simultaneous events:
  - flush_m overrides stall_m for both M and W.
  - stall_m held N cycles: M is frozen, including m_tnew (no countdown), and W sees N bubbles.
- Reset mid-stream: in-flight instructions are discarded. There are no spurious GRF writes after reset deasserts until a new valid E capture has propagated 2 edges.
- Purely registered outputs: no combinational path from E inputs to any output. The only combinational input-to-output dependency is none; m_rdata affects only W registers.

Decomposition:
- Shared package: source encodings SEL_ANS=2'b00, SEL_MEM=2'b01, SEL_PCLINK=2'b10, SEL_RSVD=2'b11.
- Shared package: zero-register constant REG_ZERO.
- One natural sub-module, wdata_stage_reg: a generic pipeline register with valid/addr/data/sel/tnew fields plus hold/bubble controls, instantiated for M and W.
- The source-select logic stays in the top.

Test Plan:
- ALU path: e_valid=1, sel=00, ans=0x1234, waddr=8, tnew=1 -> next edge fwd_m_addr=8, fwd_m_ready=0 (m_tnew=0? no, 1-1=0 -> ready=1). Following edge grf_we=1, addr=8, data=0x1234.
- Link path: sel=10, e_pc=0x00003000, waddr=31, tnew=0 -> fwd_m_data=0x00003008, ready=1. Then grf_wdata=0x00003008. Also e_pc=0xFFFFFFFC -> 0x00000004.
- Load: sel=01, waddr=4, tnew=2, m_rdata=0xDEADBEEF at the M->W edge -> fwd_m_ready=0, m_tnew=1. Then grf_wdata=0xDEADBEEF.
- $0 suppression: e_valid=1, waddr=0, ans=5 -> fwd_m_addr=0 and grf_we stays 0 for all cycles.
- Stall/flush: load in M, stall_m=1 for 2 cycles -> M fields constant, grf_we=0 for 2 cycles, then write. Assert flush_m with stall_m -> M bubbled, no write.
- Async reset: assert reset between edges while M and W are valid -> all outputs 0 immediately. Deassert -> grf_we=0 until a new capture propagates 2 edges.
